// File: rtl/counter_timer_ctrl.sv
// Start/stop/pause sequencer for a WIDTH-bit up counter with terminal-count tick.
// Optional prescaler on the count step: define PRESCALE_EN.
module counter_timer_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             step;

`ifdef PRESCALE_EN
  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_clear;
  logic             div_run;

  // Divider restarts on any accepted start or stop so the first step is a full PRESCALE away.
  assign div_clear = stop || (start && (period != '0));
  assign div_run   = (state_q == RUN) && !pause;
  assign step      = (div_q == DIV_W'(PRESCALE - 1));

  always_comb begin
    div_d = div_q;
    if (div_clear) begin
      div_d = '0;
    end else if (div_run) begin
      div_d = step ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign step = 1'b1;
`endif

  // Priority: stop > start > pause > count step (reset handled in the register).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      if (period != '0) begin
        period_d = period;
        mode_d   = mode;
        count_d  = '0;
        state_d  = RUN;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (step) begin
            if (count_q == period_q) begin
              tick_d = 1'b1;
              if (mode_q) begin
                count_d = '0;
              end else begin
                state_d = DONE;
              end
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign tick  = tick_q;
  assign err   = err_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSED);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench for counter_timer_ctrl; expected values are hand-derived.
// Build with PRESCALE_EN defined to exercise the prescaled one-shot case.
module tb_counter_timer_ctrl;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;

  logic             clock;
  logic             reset;
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             tick;
  logic             done;
  logic             err;

  int checks;
  int failures;

  counter_timer_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .mode  (mode),
    .period(period),
    .count (count),
    .state (state),
    .busy  (busy),
    .tick  (tick),
    .done  (done),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; period = 4'd5; mode = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({count, state, busy, done, tick, err} !== 10'b0) begin
      failures++;
      $display("FAIL reset: count=%0d state=%b busy=%b done=%b tick=%b err=%b expected all 0",
               count, state, busy, done, tick, err);
    end
    reset = 1'b0; start = 1'b0;
    cycle();
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL reset_release_idle: state=%b expected 00", state);
    end
  endtask

  task automatic test_oneshot();
    start = 1'b1; mode = 1'b0; period = 4'd5;
    cycle();
    start = 1'b0; period = 4'd9;  // latched copy must be used
    checks++;
    if (count !== 4'd0 || state !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_start: count=%0d state=%b busy=%b expected 0 01 1", count, state, busy);
    end
    for (int i = 1; i <= 5; i++) begin
      cycle();
      checks++;
      if (count !== 4'(i) || tick !== 1'b0 || state !== 2'b01) begin
        failures++;
        $display("FAIL oneshot_count: count=%0d tick=%b state=%b expected %0d 0 01", count, tick, state, i);
      end
    end
    cycle();
    checks++;
    if (tick !== 1'b1 || state !== 2'b11 || done !== 1'b1 || count !== 4'd5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_term: tick=%b state=%b done=%b count=%0d busy=%b expected 1 11 1 5 0",
               tick, state, done, count, busy);
    end
    pause = 1'b1;  // ignored in DONE
    cycle();
    cycle();
    pause = 1'b0;
    checks++;
    if (tick !== 1'b0 || state !== 2'b11 || count !== 4'd5) begin
      failures++;
      $display("FAIL oneshot_hold: tick=%b state=%b count=%0d expected 0 11 5", tick, state, count);
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    checks++;
    if (state !== 2'b00 || count !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL done_stop: state=%b count=%0d done=%b expected 00 0 0", state, count, done);
    end
  endtask

  task automatic test_periodic(input logic [WIDTH-1:0] p, input int steps);
    int exp_count;
    start = 1'b1; mode = 1'b1; period = p;
    cycle();
    start = 1'b0; period = 4'd1;
    for (int i = 1; i <= steps; i++) begin
      cycle();
      exp_count = i % (int'(p) + 1);
      checks++;
      if (count !== 4'(exp_count) || tick !== (exp_count == 0) || state !== 2'b01) begin
        failures++;
        $display("FAIL periodic_p%0d: step=%0d count=%0d tick=%b state=%b expected %0d %b 01",
                 p, i, count, tick, state, exp_count, exp_count == 0);
      end
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic test_pause();
    start = 1'b1; mode = 1'b1; period = 4'd7;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (state !== 2'b10 || count !== 4'd2 || tick !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL pause_hold: state=%b count=%0d tick=%b busy=%b expected 10 2 0 1",
                 state, count, tick, busy);
      end
    end
    pause = 1'b0;
    cycle();
    checks++;
    if (state !== 2'b01 || count !== 4'd2) begin
      failures++;
      $display("FAIL pause_release: state=%b count=%0d expected 01 2", state, count);
    end
    for (int i = 3; i <= 4; i++) begin
      cycle();
      checks++;
      if (count !== 4'(i)) begin
        failures++;
        $display("FAIL pause_resume: count=%0d expected %0d", count, i);
      end
    end
    start = 1'b1; period = 4'd6;  // restart from RUN
    cycle();
    start = 1'b0;
    checks++;
    if (state !== 2'b01 || count !== 4'd0) begin
      failures++;
      $display("FAIL restart: state=%b count=%0d expected 01 0", state, count);
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic test_err_and_stop();
    start = 1'b1; period = 4'd0;
    cycle();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || state !== 2'b00 || count !== 4'd0) begin
      failures++;
      $display("FAIL err_pulse: err=%b state=%b count=%0d expected 1 00 0", err, state, count);
    end
    cycle();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%b expected 0", err);
    end
    pause = 1'b1;
    cycle();
    pause = 1'b0;
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL idle_pause: state=%b expected 00", state);
    end
    start = 1'b1; mode = 1'b0; period = 4'd5;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    stop = 1'b1; start = 1'b1;
    cycle();
    stop = 1'b0; start = 1'b0;
    checks++;
    if (state !== 2'b00 || count !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_start: state=%b count=%0d busy=%b expected 00 0 0", state, count, busy);
    end
  endtask

  task automatic test_prescale();
    int exp_count;
    start = 1'b1; mode = 1'b0; period = 4'd2;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      exp_count = (c >= 8) ? 2 : (c >= 4) ? 1 : 0;
      checks++;
      if (count !== 4'(exp_count) || tick !== (c == 12) || done !== (c == 12)) begin
        failures++;
        $display("FAIL prescale: cyc=%0d count=%0d tick=%b done=%b expected %0d %b %b",
                 c, count, tick, done, exp_count, c == 12, c == 12);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; period = '0;
    test_reset();
`ifdef PRESCALE_EN
    test_prescale();
`else
    test_oneshot();
    test_periodic(4'd3, 9);
    test_periodic(4'd15, 17);
    test_pause();
    test_err_and_stop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
